// File: rtl/stopwatch_timer_ctrl_if.sv
// Signal bundle between the stopwatch/timer sequencer and the rest of the
// chip. The controller sits on the slave side: it receives the tick, the
// debounced button levels and the timer zero flag, and drives every control
// output. The master side is the datapath/board logic.
//   tick        1   one-clk-wide 100 Hz enable
//   btn_start   1   debounced start/hr level
//   btn_pause   1   debounced pause/min level
//   btn_mode    1   debounced mode/setting level
//   zero_in     1   timer value == 00:00
//   mode        1   0 = stopwatch, 1 = timer
//   setting     1   timer init-value edit mode
//   sw_en       1   stopwatch count enable
//   sw_clr      1   one-clk stopwatch clear pulse
//   lap_hold    1   freeze stopwatch display register
//   tm_load     1   timer follows init value
//   tm_en       1   timer down-count enable
//   set_inc_hr  1   one-clk hour increment pulse
//   set_inc_min 1   one-clk minute increment pulse
//   alarm       1   timer expired
//   led         16  {14{blink}, setting, mode}
interface stopwatch_timer_ctrl_if;
  logic        tick;
  logic        btn_start;
  logic        btn_pause;
  logic        btn_mode;
  logic        zero_in;
  logic        mode;
  logic        setting;
  logic        sw_en;
  logic        sw_clr;
  logic        lap_hold;
  logic        tm_load;
  logic        tm_en;
  logic        set_inc_hr;
  logic        set_inc_min;
  logic        alarm;
  logic [15:0] led;

  modport master (
    output tick, btn_start, btn_pause, btn_mode, zero_in,
    input  mode, setting, sw_en, sw_clr, lap_hold, tm_load, tm_en,
           set_inc_hr, set_inc_min, alarm, led
  );

  modport slave (
    input  tick, btn_start, btn_pause, btn_mode, zero_in,
    output mode, setting, sw_en, sw_clr, lap_hold, tm_load, tm_en,
           set_inc_hr, set_inc_min, alarm, led
  );
endinterface

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer sequencer. One press classifier per button turns debounced
// levels into SHORT / LONG / REPEAT events; a single FSM consumes them and
// drives registered control outputs for the stopwatch and timer datapaths.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    stopwatch_timer_ctrl_if.slave (tick, buttons, zero_in in; controls out)

// Press classifier for one button.
//   i_tick    100 Hz enable
//   i_btn     debounced level
//   i_rpt_en  auto-repeat allowed (only honoured when RPT_CAP is set)
//   o_short   one-clk release-before-long event
//   o_long    one-clk event when the hold reaches LONG_TICKS
//   o_rpt     one-clk event every REPEAT_TICKS while held after LONG
module stopwatch_timer_ctrl_press #(
  parameter int LONG_TICKS   = 200,
  parameter int REPEAT_TICKS = 25,
  parameter bit RPT_CAP      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_btn,
  input  logic i_rpt_en,
  output logic o_short,
  output logic o_long,
  output logic o_rpt
);
  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic          r_prev;
  logic          r_armed;
  logic          r_long_seen;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rpt;

  logic w_rise, w_fall, w_held_tick, w_hit_long, w_hit_rpt;

  assign w_rise      = i_btn & ~r_prev;
  assign w_fall      = ~i_btn & r_prev;
  assign w_held_tick = r_armed & i_btn & r_prev & i_tick;
  assign w_hit_long  = w_held_tick & ~r_long_seen & (r_cnt == CW'(LONG_TICKS - 1));
  assign w_hit_rpt   = w_held_tick & r_long_seen & (r_rpt == RW'(REPEAT_TICKS - 1));

  // Once LONG has fired the release is swallowed.
  assign o_short = w_fall & r_armed & ~r_long_seen;
  assign o_long  = w_hit_long;
  assign o_rpt   = RPT_CAP & i_rpt_en & w_hit_rpt;

  // r_prev resets high so a button held through reset never produces a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 1'b1;
      r_armed     <= 1'b0;
      r_long_seen <= 1'b0;
      r_cnt       <= '0;
      r_rpt       <= '0;
    end else begin
      r_prev <= i_btn;
      if (w_rise) begin
        r_armed     <= 1'b1;
        r_long_seen <= 1'b0;
        r_cnt       <= '0;
        r_rpt       <= '0;
      end else if (w_fall) begin
        r_armed <= 1'b0;
      end else if (w_held_tick) begin
        if (r_cnt != CW'(LONG_TICKS)) r_cnt <= r_cnt + 1'b1;
        if (w_hit_long) begin
          r_long_seen <= 1'b1;
          r_rpt       <= '0;
        end else if (r_long_seen) begin
          r_rpt <= w_hit_rpt ? '0 : r_rpt + 1'b1;
        end
      end
    end
  end
endmodule

module stopwatch_timer_ctrl #(
  parameter int LONG_TICKS   = 200,
  parameter int REPEAT_TICKS = 25,
  parameter int BLINK_TICKS  = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stopwatch_timer_ctrl_if.slave  bus
);
  localparam int NUM_BTN = 3;  // lane 0 start, 1 pause, 2 mode
  localparam int BW      = $clog2(BLINK_TICKS + 1);

  typedef enum logic [3:0] {
    SW_IDLE, SW_RUN, SW_LAP, SW_STOP,
    TM_IDLE, TM_RUN, TM_PAUSE, TM_DONE, SET
  } state_t;

  state_t r_state, w_nxt;

  logic          r_mode, r_setting, r_sw_en, r_sw_clr, r_lap_hold;
  logic          r_tm_load, r_tm_en, r_inc_hr, r_inc_min, r_alarm, r_blink;
  logic [BW-1:0] r_bcnt;

  logic          w_mode_n, w_setting_n, w_sw_en_n, w_sw_clr_n, w_lap_hold_n;
  logic          w_tm_load_n, w_tm_en_n, w_inc_hr_n, w_inc_min_n, w_alarm_n, w_blink_n;
  logic [BW-1:0] w_bcnt_n;

  logic [NUM_BTN-1:0] w_btn, w_short, w_long, w_rpt;
  logic               w_in_set;

  assign w_btn    = {bus.btn_mode, bus.btn_pause, bus.btn_start};
  assign w_in_set = (r_state == SET);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    stopwatch_timer_ctrl_press #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .RPT_CAP     ((g < 2) ? 1'b1 : 1'b0)
    ) u_press (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tick  (bus.tick),
      .i_btn   (w_btn[g]),
      .i_rpt_en(w_in_set),
      .o_short (w_short[g]),
      .o_long  (w_long[g]),
      .o_rpt   (w_rpt[g])
    );
  end

  // Same-cycle arbitration: any mode event masks start and pause, any start
  // event masks pause.
  logic w_m_any, w_st_hit, w_pa_hit;
  logic w_m_s, w_m_l, w_st_s, w_st_inc, w_pa_s, w_pa_inc, w_any_s;

  assign w_m_any  = w_short[2] | w_long[2];
  assign w_st_hit = w_short[0] | w_long[0] | w_rpt[0];
  assign w_pa_hit = w_short[1] | w_long[1] | w_rpt[1];
  assign w_m_s    = w_short[2];
  assign w_m_l    = w_long[2];
  assign w_st_s   = w_short[0] & ~w_m_any;
  assign w_st_inc = w_st_hit & ~w_m_any;
  assign w_pa_s   = w_short[1] & ~w_m_any & ~w_st_hit;
  assign w_pa_inc = w_pa_hit & ~w_m_any & ~w_st_hit;
  assign w_any_s  = w_m_s | w_st_s | w_pa_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SW_IDLE;
      r_mode     <= 1'b0;
      r_setting  <= 1'b0;
      r_sw_en    <= 1'b0;
      r_sw_clr   <= 1'b0;
      r_lap_hold <= 1'b0;
      r_tm_load  <= 1'b0;
      r_tm_en    <= 1'b0;
      r_inc_hr   <= 1'b0;
      r_inc_min  <= 1'b0;
      r_alarm    <= 1'b0;
      r_blink    <= 1'b0;
      r_bcnt     <= '0;
    end else begin
      r_state    <= w_nxt;
      r_mode     <= w_mode_n;
      r_setting  <= w_setting_n;
      r_sw_en    <= w_sw_en_n;
      r_sw_clr   <= w_sw_clr_n;
      r_lap_hold <= w_lap_hold_n;
      r_tm_load  <= w_tm_load_n;
      r_tm_en    <= w_tm_en_n;
      r_inc_hr   <= w_inc_hr_n;
      r_inc_min  <= w_inc_min_n;
      r_alarm    <= w_alarm_n;
      r_blink    <= w_blink_n;
      r_bcnt     <= w_bcnt_n;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_sw_clr_n  = 1'b0;
    w_inc_hr_n  = 1'b0;
    w_inc_min_n = 1'b0;
    w_blink_n   = r_blink;
    w_bcnt_n    = r_bcnt;

    case (r_state)
      SW_IDLE: begin
        if (w_m_s)       w_nxt = TM_IDLE;
        else if (w_st_s) w_nxt = SW_RUN;
      end
      SW_RUN: begin
        if (w_st_s)      w_nxt = SW_STOP;
        else if (w_pa_s) w_nxt = SW_LAP;
      end
      SW_LAP: begin
        if (w_st_s)      w_nxt = SW_STOP;
        else if (w_pa_s) w_nxt = SW_RUN;
      end
      SW_STOP: begin
        if (w_st_s) begin
          w_nxt = SW_RUN;
        end else if (w_pa_s) begin
          w_nxt      = SW_IDLE;
          w_sw_clr_n = 1'b1;
        end
      end
      TM_IDLE: begin
        if (w_m_s)                      w_nxt = SW_IDLE;
        else if (w_m_l)                 w_nxt = SET;
        else if (w_st_s && !bus.zero_in) w_nxt = TM_RUN;
      end
      TM_RUN: begin
        // Expiry wins over any button event in the same cycle.
        if (bus.zero_in) begin
          w_nxt     = TM_DONE;
          w_blink_n = 1'b1;
          w_bcnt_n  = '0;
        end else if (w_pa_s) begin
          w_nxt = TM_PAUSE;
        end
      end
      TM_PAUSE: begin
        if (w_st_s)      w_nxt = TM_IDLE;
        else if (w_pa_s) w_nxt = TM_RUN;
      end
      TM_DONE: begin
        if (w_any_s) begin
          w_nxt = TM_IDLE;
        end else if (bus.tick) begin
          if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
            w_blink_n = ~r_blink;
            w_bcnt_n  = '0;
          end else begin
            w_bcnt_n = r_bcnt + 1'b1;
          end
        end
      end
      SET: begin
        if (w_m_l) w_nxt = TM_IDLE;
        w_inc_hr_n  = w_st_inc;
        w_inc_min_n = w_pa_inc;
      end
      default: w_nxt = SW_IDLE;
    endcase

    // Blink only lives inside TM_DONE.
    if (w_nxt != TM_DONE) begin
      w_blink_n = 1'b0;
      w_bcnt_n  = '0;
    end

    // Level outputs are a function of the state being entered.
    w_mode_n     = (w_nxt == TM_IDLE) || (w_nxt == TM_RUN) || (w_nxt == TM_PAUSE) ||
                   (w_nxt == TM_DONE) || (w_nxt == SET);
    w_setting_n  = (w_nxt == SET);
    w_sw_en_n    = (w_nxt == SW_RUN) || (w_nxt == SW_LAP);
    w_lap_hold_n = (w_nxt == SW_LAP);
    w_tm_load_n  = (w_nxt == TM_IDLE) || (w_nxt == SET);
    w_tm_en_n    = (w_nxt == TM_RUN);
    w_alarm_n    = (w_nxt == TM_DONE);
  end

  assign bus.mode        = r_mode;
  assign bus.setting     = r_setting;
  assign bus.sw_en       = r_sw_en;
  assign bus.sw_clr      = r_sw_clr;
  assign bus.lap_hold    = r_lap_hold;
  assign bus.tm_load     = r_tm_load;
  assign bus.tm_en       = r_tm_en;
  assign bus.set_inc_hr  = r_inc_hr;
  assign bus.set_inc_min = r_inc_min;
  assign bus.alarm       = r_alarm;
  assign bus.led         = {{14{r_blink}}, r_setting, r_mode};
endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
module tb_stopwatch_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_timer_ctrl_if bus();
  stopwatch_timer_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Pulse counters, sampled once per clock.
  int n_clr = 0, n_hr = 0, n_min = 0;
  always @(negedge clk) begin
    if (bus.sw_clr)      n_clr++;
    if (bus.set_inc_hr)  n_hr++;
    if (bus.set_inc_min) n_min++;
  end

  // {mode, setting, sw_en, lap_hold, tm_load, tm_en, alarm, led}
  function automatic logic [22:0] snap();
    return {bus.mode, bus.setting, bus.sw_en, bus.lap_hold, bus.tm_load,
            bus.tm_en, bus.alarm, bus.led};
  endfunction

  task automatic chk(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = snap();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got flags=%b led=%h, want flags=%b led=%h",
               name, act[22:16], act[15:0], exp[22:16], exp[15:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One tick window: tick high for one clk, then settle.
  task automatic tick1();
    @(negedge clk); bus.tick = 1'b1;
    @(negedge clk); bus.tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // b: 0 none, 1 start, 2 pause, 3 mode, 4 start+mode
  task automatic set_btn(input int b, input logic v);
    if (b == 1 || b == 4) bus.btn_start = v;
    if (b == 2)           bus.btn_pause = v;
    if (b == 3 || b == 4) bus.btn_mode  = v;
  endtask

  task automatic press(input int b);
    @(negedge clk); set_btn(b, 1'b1);
    repeat (2) @(negedge clk); set_btn(b, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          btn;
    logic        zero;
    logic [6:0]  flags;  // mode setting sw_en lap_hold tm_load tm_en alarm
    logic [15:0] led;
    string       name;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  localparam logic [6:0] F_OFF   = 7'b0000000;
  localparam logic [6:0] F_RUN   = 7'b0010000;
  localparam logic [6:0] F_LAP   = 7'b0011000;
  localparam logic [6:0] F_TIDLE = 7'b1000100;
  localparam logic [6:0] F_TRUN  = 7'b1000010;
  localparam logic [6:0] F_TPAU  = 7'b1000000;
  localparam logic [6:0] F_SET   = 7'b1100100;
  localparam logic [6:0] F_DONE  = 7'b1000001;

  int hits[$];
  int c0, c1, cnt_en;

  initial begin
    vecs[0]  = '{0, 1'b0, F_OFF,   16'h0000, "reset_state"};
    vecs[1]  = '{2, 1'b0, F_OFF,   16'h0000, "idle_pause_ignored"};
    vecs[2]  = '{1, 1'b0, F_RUN,   16'h0000, "idle_start_run"};
    vecs[3]  = '{2, 1'b0, F_LAP,   16'h0000, "run_pause_lap"};
    vecs[4]  = '{2, 1'b0, F_RUN,   16'h0000, "lap_pause_run"};
    vecs[5]  = '{2, 1'b0, F_LAP,   16'h0000, "run_pause_lap2"};
    vecs[6]  = '{1, 1'b0, F_OFF,   16'h0000, "lap_start_stop"};
    vecs[7]  = '{1, 1'b0, F_RUN,   16'h0000, "stop_start_run"};
    vecs[8]  = '{1, 1'b0, F_OFF,   16'h0000, "run_start_stop"};
    vecs[9]  = '{2, 1'b0, F_OFF,   16'h0000, "stop_pause_idle"};
    vecs[10] = '{3, 1'b0, F_TIDLE, 16'h0001, "mode_to_timer"};
    vecs[11] = '{1, 1'b1, F_TIDLE, 16'h0001, "tidle_start_zero_ignored"};
    vecs[12] = '{1, 1'b0, F_TRUN,  16'h0001, "tidle_start_run"};
    vecs[13] = '{2, 1'b0, F_TPAU,  16'h0001, "trun_pause"};
    vecs[14] = '{2, 1'b0, F_TRUN,  16'h0001, "tpause_resume"};
    vecs[15] = '{2, 1'b0, F_TPAU,  16'h0001, "trun_pause2"};
    vecs[16] = '{1, 1'b0, F_TIDLE, 16'h0001, "tpause_start_reload"};
    vecs[17] = '{3, 1'b0, F_OFF,   16'h0000, "tidle_mode_sw"};
    vecs[18] = '{4, 1'b0, F_TIDLE, 16'h0001, "start_mode_same_clk"};
    vecs[19] = '{3, 1'b0, F_OFF,   16'h0000, "back_to_sw"};

    bus.tick = 1'b0; bus.btn_start = 1'b0; bus.btn_pause = 1'b0;
    bus.btn_mode = 1'b0; bus.zero_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      bus.zero_in = vecs[i].zero;
      if (vecs[i].btn == 0) repeat (3) @(negedge clk);
      else                  press(vecs[i].btn);
      chk(vecs[i].name, {vecs[i].flags, vecs[i].led});
    end

    // Stopwatch run for 300 ticks, stop, clear.
    bus.zero_in = 1'b0;
    press(1);
    cnt_en = 0;
    for (int k = 0; k < 300; k++) begin
      tick1();
      if (bus.sw_en) cnt_en++;
    end
    chk_int("sw_en_300_ticks", cnt_en, 300);
    c0 = n_clr;
    press(1);
    chk("run300_start_stop", {F_OFF, 16'h0000});
    chk_int("no_clr_on_stop", n_clr - c0, 0);
    press(2);
    chk_int("clr_single_pulse", n_clr - c0, 1);
    chk("stop_pause_idle2", {F_OFF, 16'h0000});

    // Timer, long mode press into SET.
    press(3);
    chk("tidle_again", {F_TIDLE, 16'h0001});
    @(negedge clk); bus.btn_mode = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 199; k++) tick1();
    chk("not_set_at_199", {F_TIDLE, 16'h0001});
    tick1();
    chk("set_at_200", {F_SET, 16'h0003});
    bus.btn_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("set_after_release", {F_SET, 16'h0003});

    // Pause held 300 ticks in SET: long then auto-repeat.
    c0 = n_min;
    @(negedge clk); bus.btn_pause = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 300; k++) begin
      c1 = n_min;
      tick1();
      if (n_min != c1) hits.push_back(k);
    end
    bus.btn_pause = 1'b0;
    repeat (4) @(negedge clk);
    chk_int("min_pulse_count", n_min - c0, 5);
    chk_int("min_hits_size", hits.size(), 5);
    for (int j = 0; j < hits.size() && j < 5; j++)
      chk_int($sformatf("min_pulse_tick_%0d", j), hits[j], 200 + 25 * j);
    c0 = n_hr; c1 = n_min;
    press(1);
    chk_int("hr_one_pulse", n_hr - c0, 1);
    chk_int("hr_no_min", n_min - c1, 0);

    // Long mode leaves SET; its release must not act as a SHORT.
    @(negedge clk); bus.btn_mode = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 200; k++) tick1();
    bus.btn_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("set_mode_long_tidle", {F_TIDLE, 16'h0001});

    // Expiry and alarm blink.
    press(1);
    chk("timer_run", {F_TRUN, 16'h0001});
    @(negedge clk); bus.zero_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_entry", {F_DONE, 16'hFFFD});
    for (int k = 0; k < 49; k++) tick1();
    chk("blink_hold_49", {F_DONE, 16'hFFFD});
    tick1();
    chk("blink_toggle_50", {F_DONE, 16'h0001});
    for (int k = 0; k < 50; k++) tick1();
    chk("blink_toggle_100", {F_DONE, 16'hFFFD});
    press(1);
    chk("done_start_tidle", {F_TIDLE, 16'h0001});

    // Async reset in the middle of TM_RUN.
    bus.zero_in = 1'b0;
    press(1);
    chk("timer_run2", {F_TRUN, 16'h0001});
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {F_OFF, 16'h0000});
    chk_int("async_reset_pulses", {bus.sw_clr, bus.set_inc_hr, bus.set_inc_min}, 0);

    // Button held through reset is ignored until released.
    bus.btn_start = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_through_reset", {F_OFF, 16'h0000});
    press(1);
    chk("after_reset_start", {F_RUN, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
